histogram_reader: RTL and testbench
===================================

# histogram_reader

Readout engine for the histogram RAM filled by the accumulation unit. On a start pulse it sweeps every bin address in ascending order and streams each `(bin, count)` pair over a valid/ready interface, with one-cycle registered-read RAM latency. While sweeping it computes the total count and the peak bin. Optionally it writes zero back to each bin after that bin is accepted. It sits between the histogram RAM port and the downstream display/UART formatter, and owns the RAM port only while busy.

## Interface
- `MAX_NUMBER`, default 255: largest sample value. `ADDR_W = $clog2(MAX_NUMBER)`; bins are 0..2**ADDR_W-1.
- `SIZE`, default 8: bin count width in bits.

Ports:
- `CLK`  in  1  single clock; all logic is on posedge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sweep; ignored while `busy`.
- `clear_en`  in  1  sampled with `start`; 1 = zero each bin after it is accepted.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when the sweep ends.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_rd`  out  1  RAM read strobe.
- `mem_wr`  out  1  RAM write enable.
- `mem_wdata`  out  SIZE  RAM write data; always 0.
- `mem_rdata`  in  SIZE  RAM read data, valid one cycle after `mem_rd`.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  downstream ready.
- `out_bin`  out  ADDR_W  bin index of the current beat.
- `out_count`  out  SIZE  count of the current beat.
- `out_last`  out  1  high on the beat for bin 2**ADDR_W-1.
- `total`  out  SIZE+ADDR_W  sum of all accepted counts.
- `peak_bin`  out  ADDR_W  index of the largest count.
- `peak_count`  out  SIZE  largest count.

## Operation
- States: IDLE, RD, LAT, OUT, DONE.
- IDLE → RD when `start`=1.
  - Latch `clear_en`.
  - Set bin counter to 0.
  - Clear `total`, `peak_bin` and `peak_count`.
- RD: drive `mem_rd`=1 and `mem_addr`=bin. Go to LAT.
- LAT: capture `mem_rdata` into the `out_count` register. Go to OUT.
- OUT: hold `out_valid`=1. `out_bin`, `out_count` and `out_last` stay stable until accepted.
- On accept (`out_valid && out_ready`):
  - `total` += count.
  - If count > `peak_count` (strictly greater), load `peak_count`/`peak_bin`. Ties keep the lower index; an all-zero histogram gives `peak_bin`=0.
  - If `clear_en` was latched, drive `mem_wr`=1 and `mem_addr`=bin in that same cycle.
  - If bin is all-ones, go to DONE. Otherwise bin += 1 and go to RD.
- DONE: `done`=1 for one cycle, then IDLE.
- `total`, `peak_*`, `out_bin` and `out_count` hold their values until the next accepted `start`.
- `busy`=1 in RD, LAT, OUT and DONE.
- `mem_rd` and `mem_wr` are never high in the same cycle.
- `mem_addr` = 0 when neither strobe is active.
- Arithmetic: `total` is SIZE+ADDR_W bits wide and cannot overflow. The bin counter never wraps past the last bin.

## Timing
- Reset (`RST_N`=0, asynchronous): state IDLE; every output is 0, including `total` and the `peak_*` outputs; no RAM strobe.
- Reset asserted mid-sweep aborts immediately: no further write, no `done`.
- Cycle numbering, with `start` sampled at edge 0:
  - RD for bin 0 is in cycle 1.
  - `out_valid` first rises in cycle 3.
- Per bin: 3 cycles minimum (RD, LAT, OUT) when `out_ready` is held high.
- Full sweep with `out_ready`=1: 3·2**ADDR_W cycles, then the DONE cycle.
- For ADDR_W=8, `done` is high in cycle 769.
- Backpressure: OUT may last any number of cycles. A clear write occurs only on the accept edge.
- `start` while busy is ignored, including in the DONE cycle.
- `out_ready` outside OUT has no effect.

## Test plan
- Preload the RAM with bin i = i mod 256 (SIZE=8), `clear_en`=0, `out_ready`=1:
  - 256 beats in order; `out_last` only on bin 255.
  - `total`=32640, `peak_bin`=255, `peak_count`=255.
  - `done` pulses at cycle 769; RAM is unchanged.
- Same preload with `clear_en`=1: after `done`, all 256 bins read 0; exactly 256 `mem_wr` pulses, each with `mem_wdata`=0.
- Random `out_ready` at 30% duty: beat values are identical to test 1, and no beat is dropped or duplicated.
- Ties: bins 7 and 200 both = 9, all others ≤ 9 → `peak_bin`=7, `peak_count`=9. All-zero RAM → `total`=0, `peak_bin`=0.
- Reset and start edge cases:
  - Assert `RST_N`=0 during the OUT state of bin 50 with `clear_en`=1: all outputs go to 0 at once, bins ≥50 keep their contents, and no `done` occurs.
  - A following `start` sweeps again from bin 0.
  - `start` pulsed while busy: no restart, and `total` is unchanged versus a clean run.

Source files
------------

// File: rtl/histogram_reader.sv
// rtl/histogram_reader.sv - histogram RAM readout engine with total/peak and optional clear-on-read
// Sweeps every bin, streams (bin, count) beats over valid/ready, and accumulates total and peak bin.
module histogram_reader #(
  parameter int MAX_NUMBER = 255,
  parameter int SIZE       = 8,
  localparam int ADDR_W    = $clog2(MAX_NUMBER)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   start,
  input  logic                   clear_en,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic [SIZE-1:0]        mem_wdata,
  input  logic [SIZE-1:0]        mem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_bin,
  output logic [SIZE-1:0]        out_count,
  output logic                   out_last,
  output logic [SIZE+ADDR_W-1:0] total,
  output logic [ADDR_W-1:0]      peak_bin,
  output logic [SIZE-1:0]        peak_count
);

  typedef enum logic [2:0] {IDLE, RD, LAT, OUT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] bin;
  logic              clr;
  logic              accept;

  assign accept = (state == OUT) && out_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      bin        <= '0;
      clr        <= 1'b0;
      out_bin    <= '0;
      out_count  <= '0;
      total      <= '0;
      peak_bin   <= '0;
      peak_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            clr        <= clear_en;
            bin        <= '0;
            out_bin    <= '0;
            out_count  <= '0;
            total      <= '0;
            peak_bin   <= '0;
            peak_count <= '0;
            state      <= RD;
          end
        end
        RD: state <= LAT;
        LAT: begin
          out_count <= mem_rdata;
          out_bin   <= bin;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            total <= total + {{ADDR_W{1'b0}}, out_count};
            // strict compare: on ties the earlier (lower) bin keeps the peak
            if (out_count > peak_count) begin
              peak_count <= out_count;
              peak_bin   <= bin;
            end
            if (&bin) begin
              state <= DONE;
            end else begin
              bin   <= bin + 1'b1;
              state <= RD;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The clear write is tied to the accept handshake so it lands on the accept edge only.
  assign mem_rd    = (state == RD);
  assign mem_wr    = accept && clr;
  assign mem_addr  = (mem_rd || mem_wr) ? bin : '0;
  assign mem_wdata = '0;
  assign out_valid = (state == OUT);
  assign out_last  = out_valid && (&out_bin);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_histogram_reader.sv
// tb/tb_histogram_reader.sv - scoreboard bench for histogram_reader
// Random RAM images and backpressure checked against a queue-based reference model.
module tb_histogram_reader;
  localparam int SIZE = 8;
  localparam int AW   = 8;
  localparam int NB   = 256;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            start = 1'b0;
  logic            clear_en = 1'b0;
  logic            out_ready = 1'b0;
  logic            busy, done, mem_rd, mem_wr, out_valid, out_last;
  logic [AW-1:0]   mem_addr, out_bin, peak_bin;
  logic [SIZE-1:0] mem_wdata, mem_rdata, out_count, peak_count;
  logic [SIZE+AW-1:0] total;

  histogram_reader #(.MAX_NUMBER(255), .SIZE(SIZE)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .clear_en(clear_en),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_count(out_count), .out_last(out_last), .total(total),
    .peak_bin(peak_bin), .peak_count(peak_count)
  );

  always #5 CLK = ~CLK;

  logic [7:0] ram [NB];
  logic [7:0] image [NB];
  int         model_ram [NB];
  logic       load = 1'b0;

  always @(posedge CLK) begin
    if (load) begin
      for (int i = 0; i < NB; i++) ram[i] <= image[i];
    end else begin
      if (mem_rd) mem_rdata <= ram[mem_addr];
      if (mem_wr) ram[mem_addr] <= mem_wdata;
    end
  end

  int compared = 0;
  int mismatched = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [7:0] bin;
    logic [7:0] cnt;
    logic       last;
  } beat_t;
  beat_t exp_q[$];

  int rdy_mode = 0;
  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(99) < 30);
      2: out_ready = $urandom_range(1) == 1;
      default: out_ready = (out_bin != 8'd50);
    endcase
  end

  int         done_cnt = 0;
  int         wr_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_bin, prev_cnt;
  beat_t      mb;

  always @(negedge CLK) begin
    if (RST_N) begin
      if (done) done_cnt++;
      if (mem_rd || mem_wr) check("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 0);
      else check("addr_idle_zero", {24'd0, mem_addr}, 0);
      if (mem_wr) begin
        wr_cnt++;
        check("wdata_zero", {24'd0, mem_wdata}, 0);
        check("wr_addr", {24'd0, mem_addr}, {24'd0, out_bin});
        check("wr_on_accept", {31'd0, out_valid & out_ready}, 1);
      end
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 1);
        check("hold_bin", {24'd0, out_bin}, {24'd0, prev_bin});
        check("hold_count", {24'd0, out_count}, {24'd0, prev_cnt});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {24'd0, out_bin}, 32'hFFFF);
        end else begin
          mb = exp_q.pop_front();
          check("beat_bin", {24'd0, out_bin}, {24'd0, mb.bin});
          check("beat_count", {24'd0, out_count}, {24'd0, mb.cnt});
          check("beat_last", {31'd0, out_last}, {31'd0, mb.last});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_bin   = out_bin;
      prev_cnt   = out_count;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic set_image(input int kind);
    for (int i = 0; i < NB; i++) begin
      case (kind)
        0: image[i] = 8'(i);
        1: image[i] = 8'($urandom_range(255));
        2: image[i] = 8'($urandom_range(8));
        default: image[i] = 8'd0;
      endcase
    end
    if (kind == 2) begin
      image[7]   = 8'd9;
      image[200] = 8'd9;
    end
    for (int i = 0; i < NB; i++) model_ram[i] = int'(image[i]);
    @(posedge CLK); #1 load = 1'b1;
    @(posedge CLK); #1 load = 1'b0;
  endtask

  task automatic check_ram(input string name);
    int bad = 0;
    for (int i = 0; i < NB; i++) if (int'(ram[i]) != model_ram[i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic push_expected(output int et, output int epb, output int epc);
    et = 0; epb = 0; epc = 0;
    for (int i = 0; i < NB; i++) begin
      beat_t b;
      b.bin = 8'(i); b.cnt = 8'(model_ram[i]); b.last = (i == NB - 1);
      exp_q.push_back(b);
      et += model_ram[i];
      if (model_ram[i] > epc) begin epc = model_ram[i]; epb = i; end
    end
  endtask

  task automatic run_sweep(input bit clr, input bit poke);
    int et, epb, epc, cyc, first_v, wr0, dn0;
    push_expected(et, epb, epc);
    wr0 = wr_cnt; dn0 = done_cnt; first_v = 0;
    @(posedge CLK); #1 start = 1'b1; clear_en = clr;
    @(posedge CLK); #1 start = 1'b0; clear_en = $urandom_range(1) == 1;
    cyc = 1;
    forever begin
      @(negedge CLK);
      if (cyc == 1) begin
        check("busy_cycle1", {31'd0, busy}, 1);
        check("rd_cycle1", {31'd0, mem_rd}, 1);
        check("rd_addr_bin0", {24'd0, mem_addr}, 0);
      end
      if (out_valid && first_v == 0) first_v = cyc;
      if (poke && cyc == 100) start = 1'b1;
      if (poke && cyc == 101) start = 1'b0;
      if (done) break;
      if (cyc > 20000) begin
        check("sweep_timeout", cyc, 0);
        break;
      end
      @(posedge CLK);
      cyc++;
    end
    if (rdy_mode == 0 && !poke) begin
      check("done_cycle", cyc, 769);
      check("first_valid_cycle", first_v, 3);
    end
    if (poke) start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    check("idle_after_done", {31'd0, busy}, 0);
    @(negedge CLK);
    check("done_one_pulse", done_cnt - dn0, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    check("total", {16'd0, total}, et);
    check("peak_bin", {24'd0, peak_bin}, epb);
    check("peak_count", {24'd0, peak_count}, epc);
    check("clear_writes", wr_cnt - wr0, clr ? NB : 0);
    repeat (3) @(negedge CLK);
    check("no_restart", {31'd0, busy}, 0);
    check("total_held", {16'd0, total}, et);
    if (clr) for (int i = 0; i < NB; i++) model_ram[i] = 0;
    check_ram("ram_after_sweep");
    exp_q.delete();
  endtask

  initial begin
    int et, epb, epc, wr0, dn0, guard;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_total", {16'd0, total}, 0);
    check("rst_peak", {peak_bin, peak_count}, 0);
    check("rst_strobes", {30'd0, mem_rd, mem_wr}, 0);
    RST_N = 1'b1;

    set_image(0); rdy_mode = 0; run_sweep(1'b0, 1'b0);
    run_sweep(1'b1, 1'b0);
    set_image(0); rdy_mode = 1; run_sweep(1'b0, 1'b0);
    set_image(1); rdy_mode = 2; run_sweep($urandom_range(1) == 1, 1'b0);
    set_image(2); rdy_mode = 0; run_sweep(1'b0, 1'b0);
    set_image(3); run_sweep(1'b1, 1'b0);

    set_image(0); rdy_mode = 3;
    push_expected(et, epb, epc);
    wr0 = wr_cnt; dn0 = done_cnt;
    @(posedge CLK); #1 start = 1'b1; clear_en = 1'b1;
    @(posedge CLK); #1 start = 1'b0; clear_en = 1'b0;
    guard = 0;
    do begin
      @(negedge CLK);
      guard++;
    end while (!(out_valid && out_bin == 8'd50) && guard < 2000);
    check("reach_bin50", guard < 2000, 1);
    repeat (2) @(negedge CLK);
    check("total_before_reset", {16'd0, total}, 1225);
    RST_N = 1'b0;
    #1;
    check("abort_busy", {30'd0, busy, done}, 0);
    check("abort_stream", {29'd0, out_valid, out_last, out_ready & 1'b0}, 0);
    check("abort_mem", {22'd0, mem_rd, mem_wr, mem_addr}, 0);
    check("abort_total", {16'd0, total}, 0);
    check("abort_peak", {16'd0, peak_bin, peak_count}, 0);
    check("abort_out_regs", {16'd0, out_bin, out_count}, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    exp_q.delete();
    repeat (4) @(negedge CLK);
    check("abort_no_done", done_cnt - dn0, 0);
    check("abort_writes", wr_cnt - wr0, 50);
    for (int i = 0; i < 50; i++) model_ram[i] = 0;
    check_ram("ram_after_abort");
    rdy_mode = 0;
    run_sweep(1'b0, 1'b0);

    set_image(1); rdy_mode = 2; run_sweep(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
